striping: RTL
=============

Name: striping

Overview:
- Transmit-side lane splitter for the PHY.
- Takes one 32-bit word stream at clk_2f and distributes it alternately onto two 32-bit lanes, lane_0 and lane_1.
- Each lane word is held for two clk_2f cycles, so downstream clk_f logic samples a stable value.
- Slot-based and free-running: slot assignment follows a toggling phase bit, not the valid-word count. This keeps the lane-to-slot mapping fixed, so the paired lane merger can reassemble order without side-band signalling.

Parameters:
- DATA_W, 32, width of data_in and each lane.
- ALIGN_CYCLES, 4, cycles spent in ALIGN after reset before input is accepted (must be even, >=2).
- IDLE_WORD, 32'h00000000, value driven on a lane whose slot carried no valid word.
- CNT_W, 16, width of word_count and drop_count.

Ports:
- clk_2f  input  1  double-rate clock.
- reset  input  1  synchronous, active-high.
- data_in  input  DATA_W  input word.
- valid_in  input  1  data_in valid this cycle.
- ready  output  1  block is in RUN; words presented while 0 are dropped.
- lane_0  output  DATA_W  even-slot lane data.
- valid_0  output  1  lane_0 holds a valid word.
- lane_1  output  DATA_W  odd-slot lane data.
- valid_1  output  1  lane_1 holds a valid word.
- phase  output  1  current slot: 0 = lane_0 slot, 1 = lane_1 slot.
- word_count  output  CNT_W  accepted words, wrapping.
- drop_count  output  CNT_W  words dropped while not ready, saturating.

Behaviour:
- Reset: the interface is reset reset, synchronous, active-high; clock clk_2f.
  - While reset=1 at a clk_2f edge, all of the following are cleared: state<=ALIGN, align counter<=0, phase<=0, ready<=0, lane_0/lane_1<=IDLE_WORD, valid_0/valid_1<=0, word_count<=0, drop_count<=0.
  - Reset asserted mid-operation discards any held lane words at that edge; no partial output.
- phase: toggles at every edge where reset=0, in all states. The first post-reset cycle therefore has phase=0.
- State machine (2 states, registered):
  - ALIGN: ready=0. Counter increments each cycle. On the edge where the counter reaches ALIGN_CYCLES-1, go to RUN; ready=1 from the next cycle. Because ALIGN_CYCLES is even, RUN always begins at phase=0.
  - RUN: ready=1. Stays in RUN until reset. There is no other exit.
- Lane update in RUN, 1-cycle latency, registered:
  - Edge with phase=0: lane_0<=valid_in ? data_in : IDLE_WORD; valid_0<=valid_in. lane_1/valid_1 hold.
  - Edge with phase=1: same rule for lane_1/valid_1. lane_0/valid_0 hold.
  - Each lane therefore changes at most every 2 cycles; its value is stable for exactly 2 cycles.
- Lane update in ALIGN: lanes hold IDLE_WORD with valid_x=0.
  - If valid_in=1: drop_count increments, saturating at all-ones. No lane update.
- word_count: increments by 1 on every RUN edge with valid_in=1. Wraps from 2^CNT_W-1 to 0.
- A gap (valid_in=0) consumes its slot. The next valid word goes to the other lane; lane order is never compacted.
- Simultaneous reset with valid_in: reset wins; the word is not counted or dropped.

Decomposition:
- Shared package phy_pkg:
  - state encoding (ST_ALIGN, ST_RUN),
  - default IDLE_WORD,
  - DATA_W constant shared with the lane merger.
- One natural sub-module: stripe_lane_reg, instantiated twice.
  - Function: per-lane data/valid register with load-enable (slot match and RUN), IDLE_WORD substitution and synchronous clear.
  - Top level keeps the FSM, phase and counters.

Test Plan:
- Reset release, valid_in=1 constantly, data_in=0xA0,0xA1,... from the first cycle:
  - ready=0 for 4 cycles, drop_count=4.
  - First accepted word 0xA4 appears on lane_0 with valid_0=1 one cycle later; 0xA5 on lane_1 the next cycle.
- RUN with a continuous stream 0x100..0x107:
  - lane_0 carries 0x100,0x102,0x104,0x106 and lane_1 carries 0x101,0x103,0x105,0x107.
  - Each value is held 2 cycles; word_count=8.
- RUN with valid_in pattern 1,0,1,1 on data 0x11,0x22,0x33,0x44:
  - lane_0=0x11 valid;
  - lane_1=IDLE_WORD with valid_1=0;
  - lane_0=0x33;
  - lane_1=0x44;
  - word_count=3.
- Reset asserted mid-stream while lane_1 holds 0x55:
  - Next edge: lanes=IDLE_WORD, valid_x=0, counters=0, phase=0.
  - ALIGN repeats for 4 cycles.
- CNT_W=4, 17 words accepted in RUN: word_count wraps to 1.
  - Separately, hold reset=0 with valid_in=1 and ALIGN_CYCLES=20: drop_count saturates at 15.
- Loopback: striping lanes connected to the lane merger on the same clk_2f.
  - A random stream with 30% gaps is reproduced in order with no loss or duplication.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY definitions for the transmit striping block and the paired lane merger.
package phy_pkg;
    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 2;
    localparam logic [DATA_W-1:0] IDLE_WORD_DEF = '0;

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/stripe_lane_reg.sv
// One output lane: data/valid register loaded in its own slot, idle word on empty slots.
module stripe_lane_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] lane,
    output logic              valid
);
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            lane  <= IDLE_WORD;
            valid <= 1'b0;
        end else if (load) begin
            lane  <= valid_in ? data_in : IDLE_WORD;
            valid <= valid_in;
        end
    end
endmodule

// File: rtl/striping.sv
// Splits a clk_2f word stream across two lanes by a free-running slot phase;
// each lane word is held two cycles for clk_f consumers.
module striping
    import phy_pkg::*;
#(
    parameter int                DATA_W       = phy_pkg::DATA_W,
    parameter int                ALIGN_CYCLES = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD    = IDLE_WORD_DEF,
    parameter int                CNT_W        = 16
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready,
    output logic [DATA_W-1:0] lane_0,
    output logic              valid_0,
    output logic [DATA_W-1:0] lane_1,
    output logic              valid_1,
    output logic              phase,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  drop_count
);
    localparam int AW = (ALIGN_CYCLES > 2) ? $clog2(ALIGN_CYCLES) : 1;

    state_t                               state, state_nxt;
    logic   [AW-1:0]                      align_cnt;
    logic                                 run;
    logic   [NUM_LANES-1:0]               lane_sel;
    logic   [NUM_LANES-1:0][DATA_W-1:0]   lane_q;
    logic   [NUM_LANES-1:0]               lane_vld;

    assign run   = (state == ST_RUN);
    assign ready = run;

    always_ff @(posedge clk_2f) begin
        if (reset) state <= ST_ALIGN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_ALIGN && align_cnt == AW'(ALIGN_CYCLES - 1))
            state_nxt = ST_RUN;
    end

    // Phase runs in every state; an even ALIGN length makes RUN open on slot 0.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            align_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            phase <= ~phase;
            if (!run) align_cnt <= align_cnt + AW'(1);
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            word_count <= '0;
            drop_count <= '0;
        end else if (valid_in) begin
            if (run)                   word_count <= word_count + CNT_W'(1);
            else if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end
    end

    // Slots are consumed whether or not a word arrives, so lane order is never compacted.
    assign lane_sel = run ? (phase ? 2'b10 : 2'b01) : 2'b00;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        stripe_lane_reg #(
            .DATA_W   (DATA_W),
            .IDLE_WORD(IDLE_WORD)
        ) u_lane (
            .clk_2f  (clk_2f),
            .reset   (reset),
            .load    (lane_sel[i]),
            .data_in (data_in),
            .valid_in(valid_in),
            .lane    (lane_q[i]),
            .valid   (lane_vld[i])
        );
    end

    assign lane_0  = lane_q[0];
    assign valid_0 = lane_vld[0];
    assign lane_1  = lane_q[1];
    assign valid_1 = lane_vld[1];
endmodule
